// File: rtl/pll_stim_sequencer_if.sv
// Control/status bundle between the bring-up harness and the PLL stimulus sequencer.
interface pll_stim_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             free_run;
  logic [CNT_W-1:0] ref_half;
  logic [CNT_W-1:0] vco_half;
  logic [CNT_W-1:0] num_toggles;
  logic             soc_reset;
  logic             pll_en_vco;
  logic             pll_ref;
  logic             pll_vco_in;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output start, stop, free_run, ref_half, vco_half, num_toggles,
    input  soc_reset, pll_en_vco, pll_ref, pll_vco_in, busy, done, cfg_err
  );

  modport slave (
    input  start, stop, free_run, ref_half, vco_half, num_toggles,
    output soc_reset, pll_en_vco, pll_ref, pll_vco_in, busy, done, cfg_err
  );
endinterface

// File: rtl/pll_stim_sequencer.sv
// Power-on stimulus: delay, SoC reset pulse, PLL enable, then REF/VCO_IN
// toggling with independent half-periods, counted or free-running.
module pll_stim_sequencer #(
  parameter int CNT_W   = 16,
  parameter int RST_DLY = 2,
  parameter int RST_LEN = 10
) (
  input  logic                 CLK,
  input  logic                 reset,
  pll_stim_sequencer_if.slave  bus
);

  localparam int PH_MAX = (RST_DLY > RST_LEN) ? RST_DLY : RST_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  DLY_LAST = PH_W'(RST_DLY - 1);
  localparam logic [PH_W-1:0]  LEN_LAST = PH_W'(RST_LEN - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, PRE, RST, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [PH_W-1:0]  ph_cnt, ph_cnt_n;
  logic [CNT_W-1:0] ref_cnt, ref_cnt_n, vco_cnt, vco_cnt_n, tog_cnt, tog_cnt_n;
  logic [CNT_W-1:0] ref_h, ref_h_n, vco_h, vco_h_n, num_t, num_t_n;
  logic             fr, fr_n;
  logic             soc_q, soc_n, en_q, en_n, ref_q, ref_n, vco_q, vco_n;
  logic             busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic [CNT_W-1:0] tog_inc;

  assign bus.soc_reset  = soc_q;
  assign bus.pll_en_vco = en_q;
  assign bus.pll_ref    = ref_q;
  assign bus.pll_vco_in = vco_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

  assign tog_inc = tog_cnt + ONE;

  // State, counters, latched config and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      ref_cnt <= '0;
      vco_cnt <= '0;
      tog_cnt <= '0;
      ref_h   <= '0;
      vco_h   <= '0;
      num_t   <= '0;
      fr      <= 1'b0;
      soc_q   <= 1'b0;
      en_q    <= 1'b0;
      ref_q   <= 1'b0;
      vco_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      ph_cnt  <= ph_cnt_n;
      ref_cnt <= ref_cnt_n;
      vco_cnt <= vco_cnt_n;
      tog_cnt <= tog_cnt_n;
      ref_h   <= ref_h_n;
      vco_h   <= vco_h_n;
      num_t   <= num_t_n;
      fr      <= fr_n;
      soc_q   <= soc_n;
      en_q    <= en_n;
      ref_q   <= ref_n;
      vco_q   <= vco_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state;
    ph_cnt_n  = ph_cnt;
    ref_cnt_n = ref_cnt;
    vco_cnt_n = vco_cnt;
    tog_cnt_n = tog_cnt;
    ref_h_n   = ref_h;
    vco_h_n   = vco_h;
    num_t_n   = num_t;
    fr_n      = fr;
    soc_n     = soc_q;
    en_n      = en_q;
    ref_n     = ref_q;
    vco_n     = vco_q;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        // stop wins over a simultaneous start
        if (bus.start && !bus.stop) begin
          if (bus.ref_half != '0 && bus.vco_half != '0) begin
            ref_h_n  = bus.ref_half;
            vco_h_n  = bus.vco_half;
            num_t_n  = bus.num_toggles;
            fr_n     = bus.free_run;
            ph_cnt_n = '0;
            state_n  = PRE;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      PRE: begin
        if (ph_cnt == DLY_LAST) begin
          ph_cnt_n = '0;
          soc_n    = 1'b1;
          en_n     = 1'b1;
          state_n  = RST;
        end else begin
          ph_cnt_n = ph_cnt + PH_ONE;
        end
      end
      RST: begin
        if (ph_cnt == LEN_LAST) begin
          ph_cnt_n  = '0;
          soc_n     = 1'b0;
          ref_cnt_n = '0;
          vco_cnt_n = '0;
          tog_cnt_n = '0;
          ref_n     = 1'b0;
          vco_n     = 1'b0;
          state_n   = RUN;
        end else begin
          ph_cnt_n = ph_cnt + PH_ONE;
        end
      end
      RUN: begin
        if (!fr && num_t == '0) begin
          // zero-length counted run: leave without any edge
          state_n = DONE;
          done_n  = 1'b1;
          en_n    = 1'b0;
          ref_n   = 1'b0;
          vco_n   = 1'b0;
        end else begin
          if (vco_cnt == vco_h - ONE) begin
            vco_n     = ~vco_q;
            vco_cnt_n = '0;
          end else begin
            vco_cnt_n = vco_cnt + ONE;
          end
          if (ref_cnt == ref_h - ONE) begin
            ref_n     = ~ref_q;
            ref_cnt_n = '0;
            if (tog_cnt != '1) tog_cnt_n = tog_inc;
            if (!fr && tog_inc == num_t) begin
              // the final toggle lands together with DONE, which parks REF low
              state_n = DONE;
              done_n  = 1'b1;
              en_n    = 1'b0;
              ref_n   = 1'b0;
              vco_n   = 1'b0;
            end
          end else begin
            ref_cnt_n = ref_cnt + ONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (bus.stop && state != IDLE) begin
      state_n = IDLE;
      soc_n   = 1'b0;
      en_n    = 1'b0;
      ref_n   = 1'b0;
      vco_n   = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_pll_stim_sequencer.sv
// Directed bench for pll_stim_sequencer with RST_DLY=2, RST_LEN=3.
module tb_pll_stim_sequencer;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  pll_stim_sequencer_if #(.CNT_W(16)) bus ();

  pll_stim_sequencer #(.CNT_W(16), .RST_DLY(2), .RST_LEN(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // {soc_reset, pll_en_vco, pll_ref, pll_vco_in, busy, done, cfg_err}
  logic [6:0] obs;
  assign obs = {bus.soc_reset, bus.pll_en_vco, bus.pll_ref, bus.pll_vco_in,
                bus.busy, bus.done, bus.cfg_err};

  // Expected output vector after each edge of a ref=3/vco=2/num=4 counted run.
  logic [6:0] trace [0:18] = '{
    7'h04, 7'h04, 7'h64, 7'h64, 7'h64, 7'h24, 7'h24, 7'h2C, 7'h3C, 7'h34,
    7'h34, 7'h2C, 7'h2C, 7'h24, 7'h34, 7'h3C, 7'h3C, 7'h06, 7'h00
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cfg(input logic [15:0] rh, input logic [15:0] vh,
                     input logic [15:0] nt, input logic f);
    bus.ref_half    = rh;
    bus.vco_half    = vh;
    bus.num_toggles = nt;
    bus.free_run    = f;
  endtask

  initial begin
    int edges;
    int vedges;
    int dones;
    int idles;
    int found;
    logic pr;
    logic pv;

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cfg(16'd0, 16'd0, 16'd0, 1'b0);

    // reset state
    step(); step();
    chk("reset_outs", obs, 7'h00);
    reset = 1'b0;
    step();
    chk("idle_outs", obs, 7'h00);

    // counted run, full trace; inputs changed after acceptance must not matter
    cfg(16'd3, 16'd2, 16'd4, 1'b0);
    bus.start = 1'b1;
    edges = 0;
    pr = 1'b0;
    for (int i = 0; i <= 18; i++) begin
      step();
      if (i == 0) begin
        bus.start = 1'b0;
        cfg(16'd9, 16'd1, 16'd1, 1'b1);
      end
      chk($sformatf("count_e%0d", i), obs, trace[i]);
      if (bus.pll_ref != pr) edges++;
      pr = bus.pll_ref;
    end
    chk("count_ref_edges", edges, 4);

    // rejected start: each zero half-period
    cfg(16'd0, 16'd5, 16'd4, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("cfgerr_ref0", obs, 7'h01);
    step();
    chk("cfgerr_clear", obs, 7'h00);
    cfg(16'd5, 16'd0, 16'd4, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("cfgerr_vco0", obs, 7'h01);
    step();
    chk("cfgerr_idle", obs, 7'h00);

    // free run for 1000 RUN cycles, then stop
    cfg(16'd1, 16'd7, 16'd2, 1'b1);
    bus.start = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      step();
      bus.start = 1'b0;
    end
    chk("free_run_entry", obs, 7'h24);
    edges = 0; vedges = 0; dones = 0; idles = 0;
    pr = bus.pll_ref;
    pv = bus.pll_vco_in;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.pll_ref != pr) edges++;
      if (bus.pll_vco_in != pv) vedges++;
      if (bus.done) dones++;
      if (!bus.busy) idles++;
      pr = bus.pll_ref;
      pv = bus.pll_vco_in;
    end
    chk("free_ref_edges", edges, 1000);
    chk("free_vco_edges", vedges, 142);
    chk("free_no_done", dones, 0);
    chk("free_busy", idles, 0);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("free_stop", obs, 7'h00);
    step();
    chk("free_stop_nodone", obs, 7'h00);

    // stop in the middle of RST, then replay from PRE
    cfg(16'd3, 16'd2, 16'd4, 1'b0);
    bus.start = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      step();
      bus.start = 1'b0;
    end
    chk("rst_mid", obs, 7'h64);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("rst_stop", obs, 7'h00);
    bus.start = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      step();
      bus.start = 1'b0;
      chk($sformatf("replay_e%0d", i), obs, trace[i]);
    end
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (bus.done) found = 1;
    end
    chk("replay_done_seen", found, 1);
    step();
    chk("replay_idle", obs, 7'h00);

    // counted run with zero toggles; extra starts while busy are ignored
    cfg(16'd1, 16'd1, 16'd0, 1'b0);
    bus.start = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      step();
      bus.start = (i == 2);
      if (i == 2) cfg(16'd0, 16'd3, 16'd9, 1'b1);
    end
    chk("zero_run_entry", obs, 7'h24);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("zero_done", obs, 7'h06);
    step();
    chk("zero_idle", obs, 7'h00);

    // reset mid-RUN together with start and stop
    cfg(16'd3, 16'd2, 16'd100, 1'b0);
    bus.start = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      step();
      bus.start = 1'b0;
    end
    chk("pre_reset_run", obs, 7'h3C);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    step();
    chk("reset_mid_run", obs, 7'h00);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    step();
    chk("after_reset_idle", obs, 7'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_stim_sequencer.md
Name: pll_stim_sequencer

Overview:
- Synthesizable, parametrised successor to the SoC bring-up stimulus. From one master clock it runs the power-on sequence: delay, then a SoC reset pulse, then PLL enable, then REF and VCO_IN toggling with independent programmable half-periods.
- Runs either for a counted number of REF toggles or free-running, and can be aborted.
- Sits ahead of vsdbabysoc in the FPGA/emulation harness and replaces the fixed-timing procedural stimulus.

Parameters:
- CNT_W, 16, width of the half-period and toggle-count fields.
- RST_DLY, 2, cycles between sequence start and soc_reset assertion; must be ≥1.
- RST_LEN, 10, cycles soc_reset is held high; must be ≥1.

Ports:
- CLK  in  1  master clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence.
- stop  in  1  abort; highest priority after reset.
- free_run  in  1  1 = toggle until stop; 0 = stop after num_toggles REF toggles.
- ref_half  in  CNT_W  REF half-period in CLK cycles.
- vco_half  in  CNT_W  VCO_IN half-period in CLK cycles.
- num_toggles  in  CNT_W  REF toggle count for counted mode.
- soc_reset  out  1  reset to the SoC.
- pll_en_vco  out  1  PLL_EN_VCO.
- pll_ref  out  1  PLL_REF.
- pll_vco_in  out  1  PLL_VCO_IN.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a counted run completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- All outputs are registered.
- On reset: state IDLE, all outputs 0, all counters 0. Reset takes priority over stop and start.
- States are IDLE, PRE, RST, RUN, DONE.
- IDLE:
  - start=1 with ref_half≠0 and vco_half≠0: latch ref_half, vco_half, num_toggles and free_run; go to PRE; busy=1 from the next cycle.
  - start=1 with either half-period =0: stay in IDLE; cfg_err=1 for one cycle.
- PRE: lasts exactly RST_DLY cycles with soc_reset=0; then go to RST.
- RST:
  - soc_reset=1 for exactly RST_LEN cycles.
  - pll_en_vco goes 1 on RST entry and stays 1 through RUN.
  - Then go to RUN with soc_reset=0.
- RUN:
  - On entry: ref_cnt, vco_cnt and tog_cnt are 0; pll_ref and pll_vco_in are 0.
  - Each cycle both counters increment independently.
  - When ref_cnt==ref_half−1: pll_ref inverts, ref_cnt←0, tog_cnt+1. VCO works the same way with vco_half, but has no toggle count.
  - First REF edge appears ref_half cycles after RUN entry; REF period is 2×ref_half cycles.
  - Counted mode: the cycle on which the toggle making tog_cnt==num_toggles is registered also moves to DONE.
  - Counted mode with num_toggles=0: go to DONE after one RUN cycle with no toggles.
  - Free-run: tog_cnt saturates at all-ones and never ends RUN.
- DONE:
  - Lasts one cycle: done=1, pll_en_vco=0, pll_ref=0, pll_vco_in=0, busy=1.
  - Then go to IDLE, where busy=0.
- stop=1 in PRE, RST, RUN or DONE: next state IDLE; all outputs 0; done is not pulsed.
- stop=1 in IDLE has no effect, and stop takes priority over a simultaneous start.
- start while busy is ignored; no cfg_err and no relatch.
- Inputs ref_half, vco_half, num_toggles and free_run are sampled only when start is accepted. Changes during a run have no effect.
- ref_half=1 or vco_half=1 toggles the output every cycle.

Test Plan:
- Reset with RST_DLY=2, RST_LEN=3; start with ref_half=3, vco_half=2, num_toggles=4, free_run=0 → soc_reset high for exactly 3 cycles starting 2 cycles after PRE entry. First REF edge 3 cycles and first VCO edge 2 cycles after RUN entry. Exactly 4 REF edges, then done for 1 cycle; busy drops the cycle after.
- Start with ref_half=0, vco_half=5 → cfg_err pulse of 1 cycle; busy, soc_reset and pll_en_vco stay 0.
- free_run=1, ref_half=1, vco_half=7 → REF toggles every cycle and VCO every 7 cycles for 1000 cycles with no done. Assert stop → next cycle all outputs 0 and busy=0, with no done.
- Assert stop in the middle of RST → soc_reset drops the next cycle and the FSM returns to IDLE. A new start then replays the full sequence from PRE.
- Counted run with num_toggles=0 → zero REF edges and done exactly 1 RUN cycle after RST. A second start pulsed during the run is ignored.
- Assert reset mid-RUN together with start and stop → next cycle IDLE with all outputs 0.
